// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the reloadable FIR filter.
package fir_pkg;

  localparam int unsigned DEF_IN_WIDTH    = 16;
  localparam int unsigned DEF_COEFF_WIDTH = 16;
  localparam int unsigned DEF_N_TAPS      = 16;
  localparam int unsigned DEF_OUT_WIDTH   = 16;
  localparam int unsigned DEF_OUT_SHIFT   = 15;

  // Wide enough for any legal accumulator plus the rounding offset.
  localparam int unsigned CALC_WIDTH = 128;

  typedef logic signed [CALC_WIDTH-1:0] calc_t;

  typedef struct packed {
    logic  sat;
    calc_t val;
  } round_t;

  function automatic int unsigned accum_width(input int unsigned in_w,
                                              input int unsigned coeff_w,
                                              input int unsigned n_taps);
    return in_w + coeff_w + $clog2(n_taps);
  endfunction

  // Round half up, arithmetic shift, then clip to an out_w-bit signed range.
  function automatic round_t round_sat(input calc_t acc, input int unsigned shift,
                                       input int unsigned out_w);
    round_t r;
    calc_t  v;
    calc_t  max_v;
    calc_t  min_v;
    v = acc;
    if (shift > 0) v = v + (calc_t'(1) <<< (shift - 1));
    v = v >>> shift;
    max_v = (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    min_v = -(calc_t'(1) <<< (out_w - 1));
    if (v > max_v) begin
      r.sat = 1'b1;
      r.val = max_v;
    end else if (v < min_v) begin
      r.sat = 1'b1;
      r.val = min_v;
    end else begin
      r.sat = 1'b0;
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form stage: coefficient multiply, add of the downstream partial
// sum, and a register that advances only on accepted samples.
module fir_tap import fir_pkg::*; #(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned ACCUM_WIDTH = 34
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic signed [IN_WIDTH-1:0]    x,
  input  logic signed [COEFF_WIDTH-1:0] coef,
  input  logic signed [ACCUM_WIDTH-1:0] sum_in,
  output logic signed [ACCUM_WIDTH-1:0] sum_out
);

  logic signed [ACCUM_WIDTH-1:0] x_ext;
  logic signed [ACCUM_WIDTH-1:0] coef_ext;
  logic signed [ACCUM_WIDTH-1:0] prod;

  assign x_ext    = {{(ACCUM_WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  assign coef_ext = {{(ACCUM_WIDTH-COEFF_WIDTH){coef[COEFF_WIDTH-1]}}, coef};
  assign prod     = x_ext * coef_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out <= '0;
    end else if (flush) begin
      sum_out <= '0;
    end else if (en) begin
      sum_out <= prod + sum_in;
    end
  end

endmodule

// File: rtl/reloadable_fir_filter.sv
// Transposed-form FIR with double-buffered coefficients, flush, and a registered
// round/saturate output stage.
module reloadable_fir_filter import fir_pkg::*; #(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned N_TAPS      = DEF_N_TAPS,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT   = DEF_OUT_SHIFT,
  localparam int unsigned ADDR_WIDTH = $clog2(N_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [IN_WIDTH-1:0]    x,
  input  logic                          flush,
  input  logic                          coef_wr_en,
  input  logic [ADDR_WIDTH-1:0]         coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_wr_data,
  input  logic                          coef_commit,
  output logic                          out_valid,
  output logic signed [OUT_WIDTH-1:0]   y,
  output logic                          sat
);

  localparam int unsigned ACCUM_WIDTH = accum_width(IN_WIDTH, COEFF_WIDTH, N_TAPS);

  logic signed [COEFF_WIDTH-1:0] shadow_q [N_TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_d [N_TAPS];
  logic signed [COEFF_WIDTH-1:0] active_q [N_TAPS];
  logic signed [ACCUM_WIDTH-1:0] sums [1:N_TAPS];
  logic signed [ACCUM_WIDTH-1:0] x_ext;
  logic signed [ACCUM_WIDTH-1:0] c0_ext;
  logic signed [ACCUM_WIDTH-1:0] acc0;
  logic                          step;
  round_t                        rs;

  assign step = in_valid & ~flush;

  // A write in the same cycle as a commit is folded into the committed bank.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) shadow_d[k] = shadow_q[k];
    if (coef_wr_en && (int'(coef_addr) < N_TAPS)) shadow_d[coef_addr] = coef_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_TAPS; k++) shadow_q[k] <= shadow_d[k];
      if (coef_commit) begin
        for (int k = 0; k < N_TAPS; k++) active_q[k] <= shadow_d[k];
      end
    end
  end

  assign sums[N_TAPS] = '0;

  for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
    fir_tap #(
      .IN_WIDTH   (IN_WIDTH),
      .COEFF_WIDTH(COEFF_WIDTH),
      .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_tap (
      .clk    (clk),
      .rst    (rst),
      .en     (step),
      .flush  (flush),
      .x      (x),
      .coef   (active_q[k]),
      .sum_in (sums[k+1]),
      .sum_out(sums[k])
    );
  end

  // Tap 0 feeds the output register directly, giving one cycle of latency.
  assign x_ext  = {{(ACCUM_WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  assign c0_ext = {{(ACCUM_WIDTH-COEFF_WIDTH){active_q[0][COEFF_WIDTH-1]}}, active_q[0]};
  assign acc0   = x_ext * c0_ext + sums[1];
  assign rs     = round_sat(calc_t'(acc0), OUT_SHIFT, OUT_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= step;
      if (step) begin
        y   <= OUT_WIDTH'(rs.val);
        sat <= rs.sat;
      end
    end
  end

endmodule

// File: tb/tb_reloadable_fir_filter.sv
// Directed bench: three filter instances share stimulus and differ in output format.
module tb_reloadable_fir_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               flush;
  logic               coef_wr_en;
  logic               coef_commit;
  logic signed [15:0] x;
  logic signed [15:0] coef_wr_data;
  logic [1:0]         coef_addr;

  logic               ov_a, ov_s, ov_r;
  logic               sat_a, sat_s, sat_r;
  logic signed [39:0] y_a;
  logic signed [15:0] y_s;
  logic signed [15:0] y_r;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic               v;
    logic signed [15:0] x;
    logic               ev;
    logic signed [39:0] ey;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  reloadable_fir_filter #(.IN_WIDTH(16), .COEFF_WIDTH(16), .N_TAPS(4), .OUT_WIDTH(40),
                          .OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
    .coef_commit(coef_commit), .out_valid(ov_a), .y(y_a), .sat(sat_a)
  );

  reloadable_fir_filter #(.IN_WIDTH(16), .COEFF_WIDTH(16), .N_TAPS(4), .OUT_WIDTH(16),
                          .OUT_SHIFT(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
    .coef_commit(coef_commit), .out_valid(ov_s), .y(y_s), .sat(sat_s)
  );

  reloadable_fir_filter #(.IN_WIDTH(16), .COEFF_WIDTH(16), .N_TAPS(4), .OUT_WIDTH(16),
                          .OUT_SHIFT(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
    .coef_commit(coef_commit), .out_valid(ov_r), .y(y_r), .sat(sat_r)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [15:0] v);
    x        = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    coef_wr_en   = 1'b1;
    coef_addr    = 2'(a);
    coef_wr_data = 16'(d);
    tick();
    coef_wr_en   = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  task automatic load4(input int h0, input int h1, input int h2, input int h3);
    wr(0, h0);
    wr(1, h1);
    wr(2, h2);
    wr(3, h3);
    commit();
  endtask

  initial begin
    // Impulse then gapped impulse with h = {1,2,3,4}.
    tbl[0]  = '{1'b1, 16'sd1, 1'b1, 40'sd1};
    tbl[1]  = '{1'b1, 16'sd0, 1'b1, 40'sd2};
    tbl[2]  = '{1'b1, 16'sd0, 1'b1, 40'sd3};
    tbl[3]  = '{1'b1, 16'sd0, 1'b1, 40'sd4};
    tbl[4]  = '{1'b1, 16'sd0, 1'b1, 40'sd0};
    tbl[5]  = '{1'b1, 16'sd1, 1'b1, 40'sd1};
    tbl[6]  = '{1'b0, 16'sd9, 1'b0, 40'sd1};
    tbl[7]  = '{1'b0, 16'sd9, 1'b0, 40'sd1};
    tbl[8]  = '{1'b1, 16'sd0, 1'b1, 40'sd2};
    tbl[9]  = '{1'b0, 16'sd7, 1'b0, 40'sd2};
    tbl[10] = '{1'b1, 16'sd0, 1'b1, 40'sd3};
    tbl[11] = '{1'b0, 16'sd7, 1'b0, 40'sd3};
    tbl[12] = '{1'b1, 16'sd0, 1'b1, 40'sd4};
    tbl[13] = '{1'b0, 16'sd5, 1'b0, 40'sd4};
    tbl[14] = '{1'b1, 16'sd0, 1'b1, 40'sd0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; coef_wr_en = 1'b0; coef_commit = 1'b0;
    x = '0; coef_wr_data = '0; coef_addr = '0;
    #7;
    chk("reset_ov", ov_a, 0);
    chk("reset_y", y_a, 0);
    chk("reset_sat", sat_a, 0);
    chk("reset_y_s", y_s, 0);
    rst = 1'b0;

    // Shadow writes stay invisible until committed.
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    sample(16'sd1);
    chk("precommit_ov", ov_a, 1);
    chk("precommit_y", y_a, 0);
    commit();

    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].v;
      x        = tbl[i].x;
      tick();
      chk($sformatf("tbl%0d_ov", i), ov_a, tbl[i].ev);
      chk($sformatf("tbl%0d_y", i), y_a, tbl[i].ey);
      chk($sformatf("tbl%0d_sat", i), sat_a, 0);
    end
    in_valid = 1'b0;

    // Flush mid-impulse wins over a simultaneous sample.
    sample(16'sd1);
    chk("fl_y0", y_a, 1);
    sample(16'sd0);
    chk("fl_y1", y_a, 2);
    flush = 1'b1; in_valid = 1'b1; x = 16'sd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ov", ov_a, 0);
    chk("fl_hold", y_a, 2);
    sample(16'sd0);
    chk("fl_after_ov", ov_a, 1);
    chk("fl_after_y0", y_a, 0);
    sample(16'sd0);
    chk("fl_after_y1", y_a, 0);

    // Commit coincident with a sample uses the old coefficients.
    load4(1, 0, 0, 0);
    wr(0, 2);
    coef_commit = 1'b1; x = 16'sd5; in_valid = 1'b1;
    tick();
    coef_commit = 1'b0; in_valid = 1'b0;
    chk("commit_old", y_a, 5);
    sample(16'sd5);
    chk("commit_new", y_a, 10);
    coef_wr_en = 1'b1; coef_addr = 2'd0; coef_wr_data = 16'sd3; coef_commit = 1'b1;
    tick();
    coef_wr_en = 1'b0; coef_commit = 1'b0;
    sample(16'sd1);
    chk("wr_commit_same", y_a, 3);

    // Saturation with every tap at full scale.
    load4(32767, 32767, 32767, 32767);
    for (int i = 0; i < 4; i++) begin
      sample(16'sd32767);
      chk($sformatf("satp%0d_y", i), y_s, 32767);
      chk($sformatf("satp%0d_sat", i), sat_s, 1);
    end
    chk("satp_full", y_a, 64'sd4294705156);
    for (int i = 0; i < 4; i++) sample(-16'sd32768);
    chk("satn_y", y_s, -32768);
    chk("satn_sat", sat_s, 1);
    chk("satn_full", y_a, -64'sd4294836224);

    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Rounding on dut_r and exact-range edges on dut_s.
    load4(1, 0, 0, 0);
    sample(16'sd3);
    chk("rnd_p3", y_r, 2);
    chk("rnd_sat", sat_r, 0);
    sample(-16'sd3);
    chk("rnd_m3", y_r, -1);
    sample(16'sd1);
    chk("rnd_p1", y_r, 1);
    sample(-16'sd32768);
    chk("edge_min_y", y_s, -32768);
    chk("edge_min_sat", sat_s, 0);
    sample(16'sd32767);
    chk("edge_max_y", y_s, 32767);
    chk("edge_max_sat", sat_s, 0);

    // Reset mid-stream discards history and both banks.
    load4(1, 2, 3, 4);
    sample(16'sd1);
    chk("rst_pre_y", y_a, 1);
    x = 16'sd1; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ov", ov_a, 0);
    chk("rst_async_y", y_a, 0);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    sample(16'sd1);
    chk("rst_coef_ov", ov_a, 1);
    chk("rst_coef_y", y_a, 0);
    load4(1, 1, 1, 1);
    sample(16'sd0);
    chk("rst_hist_y", y_a, 0);
    sample(16'sd5);
    chk("rst_reload_y", y_a, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reloadable_fir_filter.md
RELOADABLE_FIR_FILTER -- requirements
Module: reloadable_fir_filter

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 16: signed input sample width.
REQ-002 The block SHALL have parameter COEFF_WIDTH, default 16: signed coefficient width.
REQ-003 The block SHALL have parameter N_TAPS, default 16, legal range 2..64: filter length.
REQ-004 The block SHALL have parameter OUT_WIDTH, default 16: signed output width.
REQ-005 The block SHALL have parameter OUT_SHIFT, default 15, legal range 0..ACCUM_WIDTH-1: right-shift applied to the accumulator before output.
REQ-006 The block SHALL have ports:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-high reset
 in_valid  in  1  x carries a sample this cycle
 x  in  IN_WIDTH  signed input sample
 flush  in  1  one-cycle pulse: clear filter history
 coef_wr_en  in  1  write the shadow coefficient bank
 coef_addr  in  clog2(N_TAPS)  tap index for the write
 coef_wr_data  in  COEFF_WIDTH  signed coefficient value
 coef_commit  in  1  copy the shadow bank to the active bank
 out_valid  out  1  y is valid this cycle
 y  out  OUT_WIDTH  signed, rounded, saturated output
 sat  out  1  y was clipped this cycle

Function
REQ-007 ACCUM_WIDTH SHALL be IN_WIDTH+COEFF_WIDTH+clog2(N_TAPS); all products and sums SHALL be full-precision signed at that width.
REQ-008 The filter SHALL be transposed form: y[n] = sum over k of h[k]*x[n-k], with one multiply and one add per pipeline stage.
REQ-009 Pipeline registers SHALL advance only on cycles with in_valid=1; input gaps SHALL NOT alter filter state.
REQ-010 out_valid SHALL assert exactly one cycle after each accepted in_valid, and y/sat SHALL be registered; latency is 1 cycle.
REQ-011 y and sat SHALL hold their values while out_valid=0.
REQ-012 Rounding SHALL be round-half-up: add 2^(OUT_SHIFT-1), then arithmetic right-shift by OUT_SHIFT; no rounding is applied when OUT_SHIFT=0.
REQ-013 If the shifted value falls outside the OUT_WIDTH signed range, y SHALL clip to the maximum or minimum value and sat SHALL be 1 for that output.
REQ-014 A coef_wr_en write SHALL update shadow[coef_addr] on the next edge and SHALL NOT affect the output until a commit.
REQ-015 On a coef_commit edge, the active bank SHALL load the shadow bank; if in_valid is also high that cycle, that sample SHALL use the old coefficients.
REQ-016 On a cycle with both coef_wr_en and coef_commit, the commit SHALL include the new write.
REQ-017 flush SHALL zero all pipeline registers and deassert out_valid on the next edge, leaving both coefficient banks unchanged.
REQ-018 If flush and in_valid are high together, flush SHALL win: the sample is dropped and out_valid=0.

Reset
REQ-019 rst SHALL asynchronously clear the pipeline registers, both coefficient banks, out_valid, y and sat to 0.
REQ-020 Asserting rst mid-stream SHALL discard all in-flight samples; the first output after release SHALL reflect only post-reset inputs.

Structure
REQ-021 A shared package fir_pkg SHALL hold the accum_width function, the default parameter constants, and the saturate/round helper function.
REQ-022 Each stage SHALL be an instance of sub-module fir_tap, which holds the multiply, the add, the enable-gated register and the flush clear; the top level SHALL hold the coefficient banks and the output stage.

Verification
REQ-023 Impulse test (N_TAPS=4, h={1,2,3,4}, OUT_SHIFT=0, OUT_WIDTH=40): x=1 then zeros, all valid -> y=1,2,3,4,0; sat=0 throughout.
REQ-024 Gapped input (same setup): in_valid toggling 1,0,0,1,0,1... -> same y sequence; out_valid high only the cycle after each valid input.
REQ-025 Saturation test (OUT_WIDTH=16, OUT_SHIFT=0, all h=32767): x=32767 sustained -> y=32767, sat=1; x=-32768 sustained -> y=-32768, sat=1.
REQ-026 Rounding test (h0=1, others 0, OUT_SHIFT=1): x=3 -> y=2; x=-3 -> y=-1; x=1 -> y=1.
REQ-027 Commit test: h={1,0,0,0} active, shadow h={2,0,0,0}, commit with x=5 valid -> y=5; next sample x=5 -> y=10.
REQ-028 Flush/reset test: flush mid-impulse -> out_valid=0 next cycle and following zeros give y=0. rst mid-stream -> all outputs 0 and coefficients 0 until reloaded.
